sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid/b_valid  input  1  requester A/B command valid.
REQ-006 SHALL have ports a_ready/b_ready  output  1  command accepted when valid && ready at a clk edge.
REQ-007 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr/b_addr  input  ADDR_W  command address.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports a_rsp_valid/b_rsp_valid  output  1  one-cycle completion pulse (read data or write ack).
REQ-011 SHALL have ports a_rdata/b_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-012 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1  to the SRAM.
REQ-013 SHALL have port mem_rdata  input  DATA_W  combinational SRAM read data for mem_addr.

Function
REQ-014 SHALL implement FSM states IDLE and ACCESS; IDLE -> ACCESS on any accepted command; ACCESS -> IDLE unconditionally after one cycle.
REQ-015 SHALL assert ready combinationally only in IDLE and only to the granted requester; at most one ready high per cycle.
REQ-016 SHALL grant the sole valid requester when only one is valid; SHALL grant none when neither is valid.
REQ-017 SHALL latch we/addr/wdata and granted-requester ID of the accepted command at the acceptance edge.
REQ-018 SHALL drive mem_addr/mem_wdata from the latched command; mem_we = latched we in ACCESS, 0 otherwise.
REQ-019 SHALL capture mem_rdata into the granted requester's rdata register at the end of ACCESS (reads only; writes leave rdata unchanged).
REQ-020 SHALL pulse the granted requester's rsp_valid for exactly one cycle, the cycle after ACCESS; the other rsp_valid stays 0.
REQ-021 SHALL give latency: accept at edge k, ACCESS in cycle k+1, rsp_valid in cycle k+2; a new command may be accepted in cycle k+2 (max throughput one op per 2 cycles).
REQ-022 SHALL hold mem_addr/mem_wdata stable in IDLE at last latched values.
REQ-023 SHALL make a read following a write to the same address return the written data.
REQ-024 SHALL ignore valid inputs while in ACCESS (ready low); withdrawn valid before acceptance is not an error.

Reset
REQ-025 SHALL on reset assertion immediately force state IDLE, mem_we 0, rsp_valid 0, all ready 0 until reset released.
REQ-026 SHALL reset mem_addr, mem_wdata, a_rdata, b_rdata to 0 and last-served pointer to B.
REQ-027 SHALL drop an in-flight command on reset mid-ACCESS: no rsp_valid is produced for it.

Configuration
REQ-028 SHALL, with SRAM_ARB_RR_EN defined, resolve simultaneous valids round-robin: grant the requester not served last; pointer updates on each acceptance.
REQ-029 SHALL, without SRAM_ARB_RR_EN, resolve simultaneous valids with fixed priority A over B; pointer logic absent.

Verification
REQ-030 SHALL cover: A writes 0x5A to addr 3, then A reads addr 3 -> a_rsp_valid twice; second a_rdata = 0x5A, mem_we high exactly one cycle.
REQ-031 SHALL cover: A and B both valid from reset (A rd addr 1, B rd addr 2), SRAM_ARB_RR_EN -> grants A, B, A, B on successive IDLE cycles.
REQ-032 SHALL cover: same stimulus without SRAM_ARB_RR_EN -> A granted every time, b_ready never high while a_valid held.
REQ-033 SHALL cover: B writes 0xC3 to addr 15, A reads addr 15 immediately after -> a_rdata = 0xC3, b_rsp_valid precedes a_rsp_valid by 2 cycles.
REQ-034 SHALL cover: reset asserted mid-ACCESS of A write 0xFF to addr 0 -> mem_we drops asynchronously, no a_rsp_valid, all outputs at reset values.
REQ-035 SHALL cover: no valids for 10 cycles -> ready, mem_we, rsp_valid all stay 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter: IDLE accepts one command, ACCESS drives the SRAM, response pulses the cycle after.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise A has fixed priority over B.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_state
);

  // Handshake: a command transfers on a rising clk edge where valid && ready;
  // ready is combinational, only high in IDLE, and only for the granted requester.

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_nxt;
  logic   grant_a, grant_b;
  logic   accept;
  logic   cmd_we;
  logic   cmd_id_b;

`ifdef SRAM_ARB_RR_EN
  logic last_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = last_b;
      grant_b = !last_b;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_b <= 1'b1;
    else if (accept) last_b <= grant_b;
  end
`else
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid && !a_valid;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing is offered while reset is held.
        a_ready = grant_a && !reset;
        b_ready = grant_b && !reset;
        if (a_ready || b_ready) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_we    = cmd_we;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = a_ready || b_ready;
  assign dbg_state = (state == ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_we    <= 1'b0;
      cmd_id_b  <= 1'b0;
    end else if (accept) begin
      mem_addr  <= b_ready ? b_addr  : a_addr;
      mem_wdata <= b_ready ? b_wdata : a_wdata;
      cmd_we    <= b_ready ? b_we    : a_we;
      cmd_id_b  <= b_ready;
    end
  end

  // Read data is captured on the edge that ends ACCESS; the pulse follows in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_rsp_valid <= (state == ACCESS) && !cmd_id_b;
      b_rsp_valid <= (state == ACCESS) &&  cmd_id_b;
      if (state == ACCESS && !cmd_we) begin
        if (cmd_id_b) b_rdata <= mem_rdata;
        else          a_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 16x8 SRAM on the memory side.
// Expected grant order follows SRAM_ARB_RR_EN when it is defined for the build.
module tb_sram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid, a_ready, a_we, a_rsp_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_rsp_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  logic          dbg_state;

  logic [DW-1:0] mem [16];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int  we_base;
    bit  exp_a;
    logic [DW-1:0] exp_b_rdata;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset held with both valids high.
    @(posedge clk);
    #2;
    check("rst_ready", {a_ready, b_ready}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_state", dbg_state, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // A writes 0x5A to addr 3, then reads it back.
    we_base = we_cnt;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h5A;
    #1;
    check("wr_grant", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 1'b0;
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_bus", {mem_addr, mem_wdata}, {4'd3, 8'h5A});
    check("wr_access_ready", {a_ready, b_ready}, 0);
    check("wr_state", dbg_state, 1);
    tick();
    check("wr_ack", {a_rsp_valid, b_rsp_valid}, 2'b10);
    check("wr_we_low", mem_we, 0);
    check("wr_rdata_kept", a_rdata, 0);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    #1;
    check("rd_grant", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 1'b0;
    check("rd_access_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    check("rd_access_we", mem_we, 0);
    tick();
    check("rd_rsp", {a_rsp_valid, b_rsp_valid}, 2'b10);
    check("rd_data", a_rdata, 8'h5A);
    check("idle_hold_bus", {mem_addr, mem_wdata}, {4'd3, 8'h5A});
    tick();
    check("rd_pulse_end", {a_rsp_valid, b_rsp_valid}, 0);
    check("we_cycles", we_cnt - we_base, 1);

    // Both requesters valid from reset: A rd addr 1, B rd addr 2.
    do_reset();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    for (int g = 0; g < 4; g++) begin
      exp_a = RR ? (g % 2 == 0) : 1'b1;
      #1;
      check($sformatf("arb_grant_%0d", g), {a_ready, b_ready}, exp_a ? 2'b10 : 2'b01);
      tick();
      check($sformatf("arb_access_ready_%0d", g), {a_ready, b_ready}, 0);
      tick();
      check($sformatf("arb_rsp_%0d", g), {a_rsp_valid, b_rsp_valid}, exp_a ? 2'b10 : 2'b01);
      check($sformatf("arb_rdata_%0d", g), exp_a ? a_rdata : b_rdata, exp_a ? 8'h11 : 8'h22);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    exp_b_rdata = RR ? 8'h22 : 8'h00;

    // B writes 0xC3 to addr 15, A reads addr 15 right behind it.
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd15; b_wdata = 8'hC3;
    #1;
    check("bw_grant", {a_ready, b_ready}, 2'b01);
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd15;
    #1;
    check("bw_access_ignores_a", {a_ready, b_ready}, 0);
    check("bw_mem_we", mem_we, 1);
    tick();
    check("bw_ack", {a_rsp_valid, b_rsp_valid}, 2'b01);
    check("bw_a_grant", {a_ready, b_ready}, 2'b10);
    check("bw_rdata_kept", b_rdata, exp_b_rdata);
    tick();
    a_valid = 1'b0;
    check("ar_gap", {a_rsp_valid, b_rsp_valid}, 0);
    tick();
    check("ar_rsp", {a_rsp_valid, b_rsp_valid}, 2'b10);
    check("ar_data", a_rdata, 8'hC3);

    // Reset mid-ACCESS of A write 0xFF to addr 0.
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd0; a_wdata = 8'hFF;
    tick();
    a_valid = 1'b0;
    check("mid_mem_we", mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_we_async", mem_we, 0);
    check("mid_ready", {a_ready, b_ready}, 0);
    check("mid_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    check("mid_bus", {mem_addr, mem_wdata}, 0);
    check("mid_rdata", {a_rdata, b_rdata}, 0);
    check("mid_state", dbg_state, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_rsp_%0d", i), {a_rsp_valid, b_rsp_valid}, 0);
    end
    check("mid_mem0_untouched", mem[0], 0);

    // Ten idle cycles with no requests.
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_%0d", i),
            {a_ready, b_ready, mem_we, a_rsp_valid, b_rsp_valid}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
